// File: rtl/writeback_arbiter.sv
// Writeback stage: drives the shared integer/float register-file write port from the
// in-order pipeline slot, filling idle cycles with buffered multi-cycle FPU completions.
module writeback_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic            RegWrite,
  input  logic            RegWriteF,
  input  logic [4:0]      wb_rd,
  input  logic [1:0]      ResultSrc,
  input  logic [XLEN-1:0] ALUResult,
  input  logic [XLEN-1:0] ReadData,
  input  logic [XLEN-1:0] PCPlus4,
  input  logic [XLEN-1:0] FPUResult,
  input  logic            fpu_done,
  input  logic [4:0]      fpu_rd,
  input  logic            fpu_to_int,
  input  logic [XLEN-1:0] fpu_result,
  output logic            fpu_ready,
  output logic            fifo_empty,
  output logic            overflow,
  output logic [4:0]      WA,
  output logic [XLEN-1:0] WB,
  output logic            WE,
  output logic            WEF
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [4:0]      rd;
    logic            to_int;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;

  logic            slot_active;
  logic [XLEN-1:0] slot_data;
  logic            pop;
  logic            bypass;
  logic            push;
  logic            drop;
  logic [4:0]      wa_next;
  logic [XLEN-1:0] wb_next;
  logic            we_next;
  logic            wef_next;

  assign head = mem[rd_ptr];

  // x0 slot writes are treated as idle so a pending completion can use the port.
  assign slot_active = wb_valid & (RegWriteF | (RegWrite & (wb_rd != 5'd0)));

  always_comb begin
    slot_data = ALUResult;
    case (ResultSrc)
      2'b00:   slot_data = ALUResult;
      2'b01:   slot_data = ReadData;
      2'b10:   slot_data = PCPlus4;
      default: slot_data = FPUResult;
    endcase
  end

  // Port arbitration: pipeline slot, then FIFO head, then same-cycle bypass.
  always_comb begin
    wa_next  = WA;
    wb_next  = WB;
    we_next  = 1'b0;
    wef_next = 1'b0;
    pop      = 1'b0;
    bypass   = 1'b0;
    if (slot_active) begin
      wa_next  = wb_rd;
      wb_next  = slot_data;
      we_next  = RegWrite & ~RegWriteF & (wb_rd != 5'd0);
      wef_next = RegWriteF;
    end else if (!fifo_empty) begin
      pop      = 1'b1;
      wa_next  = head.rd;
      wb_next  = head.data;
      we_next  = head.to_int & (head.rd != 5'd0);
      wef_next = ~head.to_int;
    end else if (fpu_done) begin
      bypass   = 1'b1;
      wa_next  = fpu_rd;
      wb_next  = fpu_result;
      we_next  = fpu_to_int & (fpu_rd != 5'd0);
      wef_next = ~fpu_to_int;
    end
  end

  assign push = fpu_done & fpu_ready & ~bypass;
  assign drop = fpu_done & ~fpu_ready;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Pointers, count and status flags; status flags track the registered count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fpu_ready  <= 1'b1;
      fifo_empty <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count      <= count_next;
      fpu_ready  <= (count_next != CW'(DEPTH));
      fifo_empty <= (count_next == CW'(0));
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{rd: fpu_rd, to_int: fpu_to_int, data: fpu_result};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      WA  <= '0;
      WB  <= '0;
      WE  <= 1'b0;
      WEF <= 1'b0;
    end else begin
      WA  <= wa_next;
      WB  <= wb_next;
      WE  <= we_next;
      WEF <= wef_next;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: slot priority, FIFO ordering, bypass,
// overflow and reset behaviour against hand-computed expectations.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic        RegWrite;
  logic        RegWriteF;
  logic [4:0]  wb_rd;
  logic [1:0]  ResultSrc;
  logic [31:0] ALUResult;
  logic [31:0] ReadData;
  logic [31:0] PCPlus4;
  logic [31:0] FPUResult;
  logic        fpu_done;
  logic [4:0]  fpu_rd;
  logic        fpu_to_int;
  logic [31:0] fpu_result;
  logic        fpu_ready;
  logic        fifo_empty;
  logic        overflow;
  logic [4:0]  WA;
  logic [31:0] WB;
  logic        WE;
  logic        WEF;

  int checks = 0;
  int errors = 0;

  writeback_arbiter #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .RegWrite(RegWrite), .RegWriteF(RegWriteF),
    .wb_rd(wb_rd), .ResultSrc(ResultSrc),
    .ALUResult(ALUResult), .ReadData(ReadData), .PCPlus4(PCPlus4), .FPUResult(FPUResult),
    .fpu_done(fpu_done), .fpu_rd(fpu_rd), .fpu_to_int(fpu_to_int), .fpu_result(fpu_result),
    .fpu_ready(fpu_ready), .fifo_empty(fifo_empty), .overflow(overflow),
    .WA(WA), .WB(WB), .WE(WE), .WEF(WEF)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 0; RegWrite = 0; RegWriteF = 0; wb_rd = 0; ResultSrc = 0;
    fpu_done = 0; fpu_rd = 0; fpu_to_int = 0; fpu_result = 0;
  endtask

  task automatic check_port(input string tag, input logic we_e, input logic wef_e,
                            input logic [4:0] wa_e, input logic [31:0] wb_e);
    check({tag, ".WE"},  32'(WE),  32'(we_e));
    check({tag, ".WEF"}, 32'(WEF), 32'(wef_e));
    check({tag, ".WA"},  32'(WA),  32'(wa_e));
    check({tag, ".WB"},  WB,       wb_e);
  endtask

  initial begin
    idle();
    ALUResult = 0; ReadData = 0; PCPlus4 = 0; FPUResult = 0;
    reset = 1;
    tick(); tick();
    check_port("rst", 0, 0, 5'd0, 32'h0);
    check("rst.ready", 32'(fpu_ready), 32'd1);
    check("rst.empty", 32'(fifo_empty), 32'd1);
    check("rst.ovf", 32'(overflow), 32'd0);
    reset = 0;

    // ALU writeback
    wb_valid = 1; RegWrite = 1; wb_rd = 5; ResultSrc = 2'b00; ALUResult = 32'h00001234;
    tick();
    check_port("alu", 1, 0, 5'd5, 32'h00001234);

    // PCPlus4 to x31, then FPUResult to float f0
    wb_rd = 31; ResultSrc = 2'b10; PCPlus4 = 32'h00000104;
    tick();
    check_port("pc4", 1, 0, 5'd31, 32'h00000104);
    RegWrite = 0; RegWriteF = 1; wb_rd = 0; ResultSrc = 2'b11; FPUResult = 32'hC0490FDB;
    tick();
    check_port("f0", 0, 1, 5'd0, 32'hC0490FDB);

    // Collision: slot wins, completion queued then drained
    idle();
    wb_valid = 1; RegWrite = 1; wb_rd = 3; ResultSrc = 2'b01; ReadData = 32'hDEADBEEF;
    fpu_done = 1; fpu_rd = 7; fpu_to_int = 0; fpu_result = 32'h3F800000;
    tick();
    check_port("col1", 1, 0, 5'd3, 32'hDEADBEEF);
    check("col1.empty", 32'(fifo_empty), 32'd0);
    idle();
    tick();
    check_port("col2", 0, 1, 5'd7, 32'h3F800000);
    check("col2.empty", 32'(fifo_empty), 32'd1);

    // Fill to DEPTH while slot busy, then overflow
    wb_valid = 1; RegWrite = 1; wb_rd = 1; ResultSrc = 2'b00; ALUResult = 32'h11;
    for (int i = 1; i <= 4; i++) begin
      fpu_done = 1; fpu_rd = 5'(i); fpu_to_int = 0; fpu_result = 32'h100 + 32'(i);
      tick();
    end
    check("fill.ready", 32'(fpu_ready), 32'd0);
    check("fill.ovf0", 32'(overflow), 32'd0);
    fpu_rd = 5; fpu_result = 32'h105;
    tick();
    check("ovf.set", 32'(overflow), 32'd1);
    idle();
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_port($sformatf("drain%0d", i), 0, 1, 5'(i), 32'h100 + 32'(i));
    end
    tick();
    check_port("drain_end", 0, 0, 5'd4, 32'h104);
    check("drain.empty", 32'(fifo_empty), 32'd1);
    check("drain.ready", 32'(fpu_ready), 32'd1);
    check("ovf.sticky", 32'(overflow), 32'd1);

    // x0 slot leaves the port to the FIFO head
    wb_valid = 1; RegWrite = 1; wb_rd = 1; ALUResult = 32'h22;
    fpu_done = 1; fpu_rd = 9; fpu_to_int = 0; fpu_result = 32'h40000000;
    tick();
    check_port("x0a", 1, 0, 5'd1, 32'h22);
    fpu_done = 0; wb_rd = 0;
    tick();
    check_port("x0b", 0, 1, 5'd9, 32'h40000000);
    check("x0.empty", 32'(fifo_empty), 32'd1);

    // Bypass when everything idle
    idle();
    fpu_done = 1; fpu_to_int = 1; fpu_rd = 10; fpu_result = 32'h00000001;
    tick();
    check_port("byp", 1, 0, 5'd10, 32'h00000001);
    check("byp.empty", 32'(fifo_empty), 32'd1);
    idle();
    tick();
    check_port("hold", 0, 0, 5'd10, 32'h00000001);
    fpu_done = 1; fpu_to_int = 1; fpu_rd = 0; fpu_result = 32'h55;
    tick();
    check_port("byp_x0", 0, 0, 5'd0, 32'h55);

    // Reset mid-drain discards pending completions
    idle();
    wb_valid = 1; RegWrite = 1; wb_rd = 2; ALUResult = 32'h33;
    for (int i = 0; i < 3; i++) begin
      fpu_done = 1; fpu_rd = 5'(20 + i); fpu_to_int = 0; fpu_result = 32'hA0 + 32'(i);
      tick();
    end
    check("pre_rst.empty", 32'(fifo_empty), 32'd0);
    idle();
    reset = 1;
    tick();
    check_port("rst2", 0, 0, 5'd0, 32'h0);
    check("rst2.ready", 32'(fpu_ready), 32'd1);
    check("rst2.empty", 32'(fifo_empty), 32'd1);
    check("rst2.ovf", 32'(overflow), 32'd0);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_port($sformatf("post_rst%0d", i), 0, 0, 5'd0, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
Writeback stage: the producer side of the register-file write port consumed by instruction decode (WA/WB/WE/WEF).
- Selects the in-order pipeline result and drives the shared write port of the integer and float register files.
- Multi-cycle FPU completions arrive out of band. They are buffered in a small FIFO and written back only in cycles the pipeline slot leaves the port free.
- Exposes backpressure and FIFO status to the FPU and the hazard unit.

Parameters:
DEPTH, 4, FPU completion FIFO entries (power of 2, >=2)
XLEN, 32, data width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
wb_valid  in  1  pipeline writeback slot holds an instruction
RegWrite  in  1  slot writes integer RF
RegWriteF  in  1  slot writes float RF (exclusive with RegWrite)
wb_rd  in  5  slot destination register
ResultSrc  in  2  00 ALUResult, 01 ReadData, 10 PCPlus4, 11 FPUResult
ALUResult  in  XLEN  ALU result
ReadData  in  XLEN  load data
PCPlus4  in  XLEN  link value
FPUResult  in  XLEN  single-cycle FPU result
fpu_done  in  1  multi-cycle FPU completion strobe
fpu_rd  in  5  completion destination
fpu_to_int  in  1  1 = completion targets integer RF, 0 = float RF
fpu_result  in  XLEN  completion data
fpu_ready  out  1  FIFO can accept (count < DEPTH)
fifo_empty  out  1  no pending completions
overflow  out  1  sticky: fpu_done seen while fpu_ready=0
WA  out  5  RF write address
WB  out  XLEN  RF write data
WE  out  1  integer RF write enable
WEF  out  1  float RF write enable

Behaviour:
- Reset values:
  - WA=0, WB=0, WE=0, WEF=0, overflow=0.
  - FIFO emptied: fpu_ready=1, fifo_empty=1.
  - A reset mid-drain discards all pending entries; no write is issued after reset.
- Output timing: WA/WB/WE/WEF are registered, one cycle after the selecting input cycle. At most one of WE/WEF is 1.
- Slot active: wb_valid & (RegWriteF | (RegWrite & wb_rd!=0)).
  - A slot write to x0 counts as idle and is suppressed: WE=0.
  - Float f0 is a normal register and is written.
- Data select: WB = mux(ResultSrc) of ALUResult/ReadData/PCPlus4/FPUResult.
- Per-cycle priority (the FIFO has no state machine; one of three modes per cycle):
  1. Slot active: write slot. WA=wb_rd; WE=RegWrite, WEF=RegWriteF.
  2. Else FIFO non-empty: pop head. WA=head.rd, WB=head.data; WE=head.to_int & head.rd!=0; WEF=~head.to_int.
  3. Else fpu_done: bypass, written directly with the same rule as a FIFO head; nothing is enqueued.
  4. Else WE=WEF=0. WA/WB hold their previous values.
- Enqueue: fpu_done & fpu_ready, and not consumed by bypass.
  - Push and pop in the same cycle: count unchanged.
  - fpu_ready is computed from the registered count only, so no combinational path from fpu_done.
- FIFO order is strictly FIFO. Completions never reorder among themselves.
- Full: fpu_done while fpu_ready=0 drops the completion and sets overflow. overflow is cleared only by reset.
- fifo_empty reflects the registered count. The hazard unit stalls consumers of FPU destinations until it is high.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits, range 0..DEPTH.

Test Plan:
- ALU writeback: wb_valid=1, RegWrite=1, wb_rd=5, ResultSrc=00, ALUResult=0x00001234 -> next cycle WE=1, WEF=0, WA=5, WB=0x00001234.
- Collision: slot writes x3 (ReadData=0xDEADBEEF, ResultSrc=01) while fpu_done, fpu_rd=7, fpu_to_int=0, fpu_result=0x3F800000 -> cycle+1 WE=1 WA=3 WB=0xDEADBEEF; cycle+2 WEF=1 WA=7 WB=0x3F800000; fifo_empty=1 after.
- Fill/overflow: slot active continuously; 4 completions f1..f4 -> fpu_ready=0 after 4th. 5th completion (f5) -> overflow=1 and is dropped. Drop wb_valid -> WEF on f1,f2,f3,f4 in consecutive cycles; f5 is never written.
- x0 slot: FIFO holds f9=0x40000000; slot RegWrite=1, wb_rd=0 -> next cycle WE=0, WEF=1, WA=9; FIFO empty.
- Bypass: all idle, fpu_done, fpu_to_int=1, fpu_rd=10, fpu_result=0x00000001 -> next cycle WE=1 WA=10 WB=1; fifo_empty stays 1.
- Reset mid-drain: 3 entries queued, reset pulse -> next cycle WE=WEF=0, WA=WB=0, fpu_ready=1, fifo_empty=1, overflow=0; no writes afterwards.
